// File: rtl/bitscan_pkg.sv
// Shared types and helpers for the bitscan encoder family.
package bitscan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } bitscan_state_t;

  // Index width needed to address every bit of a WIDTH-bit vector.
  // WIDTH is at least 2, so the result is never below 1.
  function automatic int idx_width(input int width);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'd1 << i) < width) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/bitscan_encoder_priority_encoder.sv
// Combinational priority encoder used by bitscan_encoder.
// MSB_FIRST selects whether the highest or the lowest set bit wins.
// idx is 0 when no bit is set; found flags any set bit and single flags
// exactly one set bit.
module priority_encoder #(
  parameter int WIDTH     = 8,
  parameter int IDX_W     = 3,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found,
  output logic             single
);

  logic [WIDTH-1:0] low_cleared_s;

  generate
    if (MSB_FIRST) begin : g_msb
      // Ascending sweep: the last hit, i.e. the highest set bit, wins.
      always_comb begin
        idx = {IDX_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
          idx = vec[i] ? IDX_W'(i) : idx;
        end
      end
    end else begin : g_lsb
      // Descending sweep: the last hit, i.e. the lowest set bit, wins.
      always_comb begin
        idx = {IDX_W{1'b0}};
        for (int i = WIDTH - 1; i >= 0; i--) begin
          idx = vec[i] ? IDX_W'(i) : idx;
        end
      end
    end
  endgenerate

  // Population flags: clearing the lowest set bit leaves zero iff at most one bit was set.
  always_comb begin
    low_cleared_s = vec & (vec - {{(WIDTH-1){1'b0}}, 1'b1});
    found         = |vec;
    single        = found & ~(|low_cleared_s);
  end

endmodule

// File: rtl/bitscan_encoder.sv
// bitscan_encoder: serialises a WIDTH-bit multi-hot vector into a stream of
// set-bit indices, one per beat, over valid/ready handshakes on both sides.
// An all-zero vector yields a single beat flagged with out_zero.
// Build option: define BITSCAN_MSB_FIRST_EN to emit the highest index first.
module bitscan_encoder
  import bitscan_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_zero
);

`ifdef BITSCAN_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  bitscan_state_t   state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             out_last_q, out_last_d;
  logic             out_zero_q, out_zero_d;

  logic             in_ready_s;
  logic             accept_s;
  logic             beat_s;
  logic             load_s;
  logic             zero_load_s;
  logic [WIDTH-1:0] clear_mask_s;
  logic [IDX_W-1:0] enc_idx_s;
  logic             enc_found_s;
  logic             enc_single_s;

  // The encoder looks at next-cycle pending so the outputs can be registered.
  priority_encoder #(
    .WIDTH     (WIDTH),
    .IDX_W     (IDX_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_penc (
    .vec    (pending_d),
    .idx    (enc_idx_s),
    .found  (enc_found_s),
    .single (enc_single_s)
  );

  // Input ready: free in IDLE, or on the final beat of a scan for back-to-back.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_q)
      IDLE:    in_ready_s = en;
      SCAN:    in_ready_s = en & out_valid_q & out_ready & out_last_q;
      default: in_ready_s = 1'b0;
    endcase
  end

  // Handshake decodes.
  always_comb begin
    accept_s     = in_valid & in_ready_s;
    beat_s       = out_valid_q & out_ready;
    clear_mask_s = {{(WIDTH-1){1'b0}}, 1'b1} << out_idx_q;
  end

  // Pending/state next values: load a new vector, retire the emitted bit, or hold.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    out_valid_d = out_valid_q;
    load_s      = 1'b0;
    zero_load_s = 1'b0;
    if (accept_s) begin
      state_d     = SCAN;
      pending_d   = in_vec;
      out_valid_d = 1'b1;
      load_s      = 1'b1;
      zero_load_s = ~(|in_vec);
    end else if (beat_s) begin
      if (out_last_q) begin
        state_d     = IDLE;
        pending_d   = {WIDTH{1'b0}};
        out_valid_d = 1'b0;
      end else begin
        pending_d   = pending_q & ~clear_mask_s;
        load_s      = 1'b1;
      end
    end else begin
      state_d     = state_q;
    end
  end

  // Output next values: present the encoder result on load, clear on scan end, else hold.
  always_comb begin
    out_idx_d  = out_idx_q;
    out_last_d = out_last_q;
    out_zero_d = out_zero_q;
    if (load_s) begin
      out_idx_d  = enc_idx_s;
      // A zero vector has no set bit but still makes one terminating beat.
      out_last_d = enc_single_s | ~enc_found_s;
      out_zero_d = zero_load_s;
    end else if (beat_s && out_last_q) begin
      out_idx_d  = {IDX_W{1'b0}};
      out_last_d = 1'b0;
      out_zero_d = 1'b0;
    end else begin
      out_zero_d = out_zero_q;
    end
  end

  // FSM, pending bits and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      out_idx_q   <= {IDX_W{1'b0}};
      out_last_q  <= 1'b0;
      out_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      out_zero_q  <= out_zero_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign out_zero  = out_zero_q;

endmodule
